// File: rtl/tlink_acquire_arbiter.sv
// ---------------------------------------------------------------------------
// tlink_acquire_arbiter
//
// Sits between N_CLIENTS uncached TileLink clients and one manager port.
//
// Acquire path:
//   - Round-robin arbitration among clients whose outstanding count is below
//     MAX_OUT.
//   - A multi-beat block write (a_type == WR_BLOCK_TYPE) locks arbitration to
//     its owner until BEATS beats have been accepted.
//   - The winner is tagged into the MSBs of client_xact_id and registered in a
//     single holding stage, so there is one cycle of latency to out_acq_*.
//
// Grant path:
//   - Combinational, zero latency.
//   - The tag in the MSBs of gnt_xid selects the owning client.
//   - Grants carrying an out-of-range tag are dropped, and route_err is set
//     and held until reset.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   in_acq_*          packed per-client Acquire channels (valid/ready/addr/
//                     xid/data/type)
//   out_acq_*         tagged Acquire towards the manager
//   gnt_*             tagged Grant from the manager
//   out_gnt_valid     per-client Grant valid
//   out_gnt_ready     per-client Grant ready
//   out_gnt_xid/data/type
//                     Grant payload broadcast to all clients, tag stripped
//   route_err         sticky: a Grant handshook with an index >= N_CLIENTS
// ---------------------------------------------------------------------------
module tlink_acquire_arbiter #(
  parameter int                N_CLIENTS     = 4,
  parameter int                ADDR_W        = 32,
  parameter int                XID_W         = 4,
  parameter int                DATA_W        = 64,
  parameter int                TYPE_W        = 3,
  parameter int                BEATS         = 4,
  parameter logic [TYPE_W-1:0] WR_BLOCK_TYPE = TYPE_W'(3),
  parameter int                MAX_OUT       = 2,
  localparam int               CIDX_W        = $clog2(N_CLIENTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  // Client Acquire channels
  input  logic [N_CLIENTS-1:0]          in_acq_valid,
  output logic [N_CLIENTS-1:0]          in_acq_ready,
  input  logic [N_CLIENTS*ADDR_W-1:0]   in_acq_addr,
  input  logic [N_CLIENTS*XID_W-1:0]    in_acq_xid,
  input  logic [N_CLIENTS*DATA_W-1:0]   in_acq_data,
  input  logic [N_CLIENTS*TYPE_W-1:0]   in_acq_type,
  // Manager Acquire channel
  output logic                          out_acq_valid,
  input  logic                          out_acq_ready,
  output logic [ADDR_W-1:0]             out_acq_addr,
  output logic [CIDX_W+XID_W-1:0]       out_acq_xid,
  output logic [DATA_W-1:0]             out_acq_data,
  output logic [TYPE_W-1:0]             out_acq_type,
  // Manager Grant channel
  input  logic                          gnt_valid,
  output logic                          gnt_ready,
  input  logic [CIDX_W+XID_W-1:0]       gnt_xid,
  input  logic [DATA_W-1:0]             gnt_data,
  input  logic [TYPE_W-1:0]             gnt_type,
  // Client Grant channels
  output logic [N_CLIENTS-1:0]          out_gnt_valid,
  input  logic [N_CLIENTS-1:0]          out_gnt_ready,
  output logic [XID_W-1:0]              out_gnt_xid,
  output logic [DATA_W-1:0]             out_gnt_data,
  output logic [TYPE_W-1:0]             out_gnt_type,
  output logic                          route_err
);

  localparam int CNT_W  = $clog2(MAX_OUT + 1);
  localparam int BEAT_W = $clog2(BEATS);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [CIDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CIDX_W-1:0]   owner_q, owner_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [CNT_W-1:0]    cnt_q [N_CLIENTS];
  logic [CNT_W-1:0]    cnt_d [N_CLIENTS];
  logic                route_err_q, route_err_d;

  logic                      hold_valid_q, hold_valid_d;
  logic [ADDR_W-1:0]         hold_addr_q, hold_addr_d;
  logic [CIDX_W+XID_W-1:0]   hold_xid_q, hold_xid_d;
  logic [DATA_W-1:0]         hold_data_q, hold_data_d;
  logic [TYPE_W-1:0]         hold_type_q, hold_type_d;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic [N_CLIENTS-1:0] elig;
  logic                 win_found;
  logic [CIDX_W-1:0]    win_idx;
  logic [CIDX_W-1:0]    cand;
  logic                 stage_free;
  logic                 acq_go;
  logic                 acq_done;

  logic [ADDR_W-1:0]    sel_addr;
  logic [XID_W-1:0]     sel_xid;
  logic [DATA_W-1:0]    sel_data;
  logic [TYPE_W-1:0]    sel_type;

  // While locked only the owner may proceed, and the outstanding limit is
  // waived so a block that has started can always finish.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    elig = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (state_q == ST_LOCKED) begin
        elig[i] = in_acq_valid[i] && (owner_q == CIDX_W'(i));
      end else begin
        elig[i] = in_acq_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUT));
      end
    end
  end

  // First eligible client at or after the round-robin pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      // NOTE: blocking assignments in combinational logic; later iterations
      // must see win_found as already updated by earlier ones.
      cand = CIDX_W'((int'(rr_ptr_q) + k) % N_CLIENTS);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_xid  = '0;
    sel_data = '0;
    sel_type = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (win_idx == CIDX_W'(i)) begin
        sel_addr = in_acq_addr[i*ADDR_W +: ADDR_W];
        sel_xid  = in_acq_xid[i*XID_W +: XID_W];
        sel_data = in_acq_data[i*DATA_W +: DATA_W];
        sel_type = in_acq_type[i*TYPE_W +: TYPE_W];
      end
    end
  end

  // The holding stage can take a new beat when it is empty or draining
  // this cycle. Ready is suppressed during reset.
  assign stage_free = !hold_valid_q || out_acq_ready;
  assign acq_go     = win_found && stage_free && !rst;

  always_comb begin
    in_acq_ready = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      in_acq_ready[i] = acq_go && (win_idx == CIDX_W'(i));
    end
  end

  // -------------------------------------------------------------------------
  // Lock / pointer / beat next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    beat_d   = beat_q;
    acq_done = 1'b0;
    if (acq_go) begin
      rr_ptr_d = (win_idx == CIDX_W'(N_CLIENTS - 1)) ? '0 : win_idx + 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (sel_type == WR_BLOCK_TYPE) begin
            state_d = ST_LOCKED;
            owner_d = win_idx;
            beat_d  = BEAT_W'(1);
          end else begin
            acq_done = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            state_d  = ST_IDLE;
            beat_d   = '0;
            acq_done = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Grant routing
  // -------------------------------------------------------------------------
  logic [CIDX_W-1:0] gnt_idx;
  logic              gnt_hit;

  assign gnt_idx = gnt_xid[CIDX_W+XID_W-1:XID_W];

  // An index with no matching client leaves gnt_ready at 1, so the Grant is
  // drained and dropped.
  always_comb begin
    gnt_hit       = 1'b0;
    gnt_ready     = 1'b1;
    out_gnt_valid = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (gnt_idx == CIDX_W'(i)) begin
        gnt_hit          = 1'b1;
        gnt_ready        = out_gnt_ready[i];
        out_gnt_valid[i] = gnt_valid;
      end
    end
  end

  assign out_gnt_xid  = gnt_xid[XID_W-1:0];
  assign out_gnt_data = gnt_data;
  assign out_gnt_type = gnt_type;

  assign route_err_d = route_err_q || (gnt_valid && !gnt_hit);

  // -------------------------------------------------------------------------
  // Outstanding counters
  // -------------------------------------------------------------------------
  // Increment on a completed Acquire, decrement on a completed Grant, and
  // leave the count unchanged when both happen together. Decrements saturate
  // at zero so spurious Grants are harmless.
  always_comb begin
    for (int i = 0; i < N_CLIENTS; i++) begin
      logic inc;
      logic dec;
      inc      = acq_done && (win_idx == CIDX_W'(i));
      dec      = out_gnt_valid[i] && out_gnt_ready[i];
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec && !inc && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Holding register next state
  // -------------------------------------------------------------------------
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_xid_d   = hold_xid_q;
    hold_data_d  = hold_data_q;
    hold_type_d  = hold_type_q;
    if (acq_go) begin
      hold_valid_d = 1'b1;
      hold_addr_d  = sel_addr;
      hold_xid_d   = {win_idx, sel_xid};
      hold_data_d  = sel_data;
      hold_type_d  = sel_type;
    end else if (out_acq_ready) begin
      hold_valid_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      beat_q       <= '0;
      route_err_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      for (int i = 0; i < N_CLIENTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      beat_q       <= beat_d;
      route_err_q  <= route_err_d;
      hold_valid_q <= hold_valid_d;
      for (int i = 0; i < N_CLIENTS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // NOTE: the payload is qualified by hold_valid_q, so it needs no reset. It
  // is kept out of the reset domain on purpose.
  always_ff @(posedge clk) begin
    hold_addr_q <= hold_addr_d;
    hold_xid_q  <= hold_xid_d;
    hold_data_q <= hold_data_d;
    hold_type_q <= hold_type_d;
  end

  assign out_acq_valid = hold_valid_q;
  assign out_acq_addr  = hold_addr_q;
  assign out_acq_xid   = hold_xid_q;
  assign out_acq_data  = hold_data_q;
  assign out_acq_type  = hold_type_q;
  assign route_err     = route_err_q;

endmodule

// File: tb/tb_tlink_acquire_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for tlink_acquire_arbiter.
//   - Main instance: N_CLIENTS=4, MAX_OUT=2, BEATS=4.
//   - Second instance: N_CLIENTS=3, used to exercise out-of-range Grant tags.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit
// later.
// ---------------------------------------------------------------------------
module tb_tlink_acquire_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Main DUT signals
  logic [3:0]     in_acq_valid, in_acq_ready;
  logic [127:0]   in_acq_addr;
  logic [15:0]    in_acq_xid;
  logic [255:0]   in_acq_data;
  logic [11:0]    in_acq_type;
  logic           out_acq_valid, out_acq_ready;
  logic [31:0]    out_acq_addr;
  logic [5:0]     out_acq_xid;
  logic [63:0]    out_acq_data;
  logic [2:0]     out_acq_type;
  logic           gnt_valid, gnt_ready;
  logic [5:0]     gnt_xid;
  logic [63:0]    gnt_data;
  logic [2:0]     gnt_type;
  logic [3:0]     out_gnt_valid, out_gnt_ready;
  logic [3:0]     out_gnt_xid;
  logic [63:0]    out_gnt_data;
  logic [2:0]     out_gnt_type;
  logic           route_err;

  tlink_acquire_arbiter #(.N_CLIENTS(4), .MAX_OUT(2), .BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .in_acq_valid(in_acq_valid), .in_acq_ready(in_acq_ready),
    .in_acq_addr(in_acq_addr), .in_acq_xid(in_acq_xid),
    .in_acq_data(in_acq_data), .in_acq_type(in_acq_type),
    .out_acq_valid(out_acq_valid), .out_acq_ready(out_acq_ready),
    .out_acq_addr(out_acq_addr), .out_acq_xid(out_acq_xid),
    .out_acq_data(out_acq_data), .out_acq_type(out_acq_type),
    .gnt_valid(gnt_valid), .gnt_ready(gnt_ready), .gnt_xid(gnt_xid),
    .gnt_data(gnt_data), .gnt_type(gnt_type),
    .out_gnt_valid(out_gnt_valid), .out_gnt_ready(out_gnt_ready),
    .out_gnt_xid(out_gnt_xid), .out_gnt_data(out_gnt_data),
    .out_gnt_type(out_gnt_type), .route_err(route_err)
  );

  // Three-client instance signals
  logic [2:0]     t_in_acq_valid, t_in_acq_ready;
  logic [95:0]    t_in_acq_addr;
  logic [11:0]    t_in_acq_xid;
  logic [191:0]   t_in_acq_data;
  logic [8:0]     t_in_acq_type;
  logic           t_out_acq_valid, t_out_acq_ready;
  logic [31:0]    t_out_acq_addr;
  logic [5:0]     t_out_acq_xid;
  logic [63:0]    t_out_acq_data;
  logic [2:0]     t_out_acq_type;
  logic           t_gnt_valid, t_gnt_ready;
  logic [5:0]     t_gnt_xid;
  logic [63:0]    t_gnt_data;
  logic [2:0]     t_gnt_type;
  logic [2:0]     t_out_gnt_valid, t_out_gnt_ready;
  logic [3:0]     t_out_gnt_xid;
  logic [63:0]    t_out_gnt_data;
  logic [2:0]     t_out_gnt_type;
  logic           t_route_err;

  tlink_acquire_arbiter #(.N_CLIENTS(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_acq_valid(t_in_acq_valid), .in_acq_ready(t_in_acq_ready),
    .in_acq_addr(t_in_acq_addr), .in_acq_xid(t_in_acq_xid),
    .in_acq_data(t_in_acq_data), .in_acq_type(t_in_acq_type),
    .out_acq_valid(t_out_acq_valid), .out_acq_ready(t_out_acq_ready),
    .out_acq_addr(t_out_acq_addr), .out_acq_xid(t_out_acq_xid),
    .out_acq_data(t_out_acq_data), .out_acq_type(t_out_acq_type),
    .gnt_valid(t_gnt_valid), .gnt_ready(t_gnt_ready), .gnt_xid(t_gnt_xid),
    .gnt_data(t_gnt_data), .gnt_type(t_gnt_type),
    .out_gnt_valid(t_out_gnt_valid), .out_gnt_ready(t_out_gnt_ready),
    .out_gnt_xid(t_out_gnt_xid), .out_gnt_data(t_out_gnt_data),
    .out_gnt_type(t_out_gnt_type), .route_err(t_route_err)
  );

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic set_client(input int c, input logic v, input logic [31:0] a,
                            input logic [3:0] x, input logic [63:0] d,
                            input logic [2:0] t);
    in_acq_valid[c]         = v;
    in_acq_addr[c*32 +: 32] = a;
    in_acq_xid[c*4 +: 4]    = x;
    in_acq_data[c*64 +: 64] = d;
    in_acq_type[c*3 +: 3]   = t;
  endtask

  task automatic idle_inputs();
    in_acq_valid    = '0;
    in_acq_addr     = '0;
    in_acq_xid      = '0;
    in_acq_data     = '0;
    in_acq_type     = '0;
    out_acq_ready   = 1'b1;
    gnt_valid       = 1'b0;
    gnt_xid         = '0;
    gnt_data        = '0;
    gnt_type        = '0;
    out_gnt_ready   = '0;
    t_in_acq_valid  = '0;
    t_in_acq_addr   = '0;
    t_in_acq_xid    = '0;
    t_in_acq_data   = '0;
    t_in_acq_type   = '0;
    t_out_acq_ready = 1'b1;
    t_gnt_valid     = 1'b0;
    t_gnt_xid       = '0;
    t_gnt_data      = '0;
    t_gnt_type      = '0;
    t_out_gnt_ready = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Tests
  // -------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    // Clients request during reset; ready must stay low.
    in_acq_valid = 4'hF;
    #1;
    n_checks++;
    if (in_acq_ready !== 4'b0000) begin
      $display("FAIL reset_in_ready: got %b want 0000", in_acq_ready);
    end else begin
      n_pass++;
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (out_acq_valid !== 1'b0) begin
      $display("FAIL reset_out_valid: got %b want 0", out_acq_valid);
    end else begin
      n_pass++;
    end
    n_checks++;
    if (route_err !== 1'b0) begin
      $display("FAIL reset_route_err: got %b want 0", route_err);
    end else begin
      n_pass++;
    end
    in_acq_valid = 4'h0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_latency();
    apply_reset();
    set_client(2, 1'b1, 32'h1000, 4'd5, 64'hD00D_0000_0000_1234, 3'd0);
    #1;
    n_checks++;
    if (in_acq_ready !== 4'b0100) begin
      $display("FAIL single_ready: got %b want 0100", in_acq_ready);
    end else begin
      n_pass++;
    end
    @(negedge clk);
    set_client(2, 1'b0, 32'h0, 4'd0, 64'h0, 3'd0);
    #1;
    n_checks++;
    if ({out_acq_valid, out_acq_xid, out_acq_addr} !== {1'b1, 6'h25, 32'h1000}) begin
      $display("FAIL single_out: got v=%b xid=%h addr=%h want v=1 xid=25 addr=00001000",
               out_acq_valid, out_acq_xid, out_acq_addr);
    end else begin
      n_pass++;
    end
    n_checks++;
    if (in_acq_ready !== 4'b0000) begin
      $display("FAIL single_ready_drop: got %b want 0000", in_acq_ready);
    end else begin
      n_pass++;
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (out_acq_valid !== 1'b0) begin
      $display("FAIL single_drain: got %b want 0", out_acq_valid);
    end else begin
      n_pass++;
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      set_client(c, 1'b1, 32'h2000 + 32'(c), 4'(c), 64'(c), 3'd0);
    end
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if (in_acq_ready !== (4'b0001 << (i % 4))) begin
        $display("FAIL rr_order[%0d]: got %b want %b", i, in_acq_ready,
                 4'b0001 << (i % 4));
      end else begin
        n_pass++;
      end
      if (i > 0) begin
        n_checks++;
        if (out_acq_xid[5:4] !== 2'((i - 1) % 4)) begin
          $display("FAIL rr_tag[%0d]: got %0d want %0d", i, out_acq_xid[5:4],
                   (i - 1) % 4);
        end else begin
          n_pass++;
        end
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_block_lock();
    logic [63:0] blk_data;
    blk_data = 64'hB10C_DA7A_5555_AAAA;
    apply_reset();
    // One single-beat from client 0 moves the pointer to 1.
    set_client(0, 1'b1, 32'h3000, 4'd1, 64'h0, 3'd0);
    #1;
    n_checks++;
    if (in_acq_ready !== 4'b0001) begin
      $display("FAIL lock_pre: got %b want 0001", in_acq_ready);
    end else begin
      n_pass++;
    end
    @(negedge clk);
    set_client(1, 1'b1, 32'h4000, 4'd7, blk_data, 3'd3);
    set_client(3, 1'b1, 32'h5000, 4'd2, 64'h33, 3'd0);
    #1;
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (in_acq_ready !== 4'b0010) begin
        $display("FAIL lock_beat_ready[%0d]: got %b want 0010", b, in_acq_ready);
      end else begin
        n_pass++;
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({out_acq_valid, out_acq_xid, out_acq_data, out_acq_type} !==
          {1'b1, 6'h17, blk_data, 3'd3}) begin
        $display("FAIL lock_beat_out[%0d]: got v=%b xid=%h data=%h type=%0d want v=1 xid=17 data=%h type=3",
                 b, out_acq_valid, out_acq_xid, out_acq_data, out_acq_type, blk_data);
      end else begin
        n_pass++;
      end
    end
    n_checks++;
    if (in_acq_ready !== 4'b1000) begin
      $display("FAIL lock_release_next: got %b want 1000", in_acq_ready);
    end else begin
      n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_outstanding_limit();
    apply_reset();
    set_client(0, 1'b1, 32'h6000, 4'd3, 64'h66, 3'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (in_acq_ready !== ((i < 2) ? 4'b0001 : 4'b0000)) begin
        $display("FAIL limit_ready[%0d]: got %b want %b", i, in_acq_ready,
                 (i < 2) ? 4'b0001 : 4'b0000);
      end else begin
        n_pass++;
      end
      @(negedge clk);
    end
    gnt_valid     = 1'b1;
    gnt_xid       = {2'd0, 4'd3};
    out_gnt_ready = 4'b0001;
    #1;
    n_checks++;
    if ({gnt_ready, out_gnt_valid, in_acq_ready} !== {1'b1, 4'b0001, 4'b0000}) begin
      $display("FAIL limit_grant: got rdy=%b gv=%b ar=%b want rdy=1 gv=0001 ar=0000",
               gnt_ready, out_gnt_valid, in_acq_ready);
    end else begin
      n_pass++;
    end
    @(negedge clk);
    gnt_valid = 1'b0;
    #1;
    n_checks++;
    if (in_acq_ready !== 4'b0001) begin
      $display("FAIL limit_resume: got %b want 0001", in_acq_ready);
    end else begin
      n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_grant_routing();
    logic [63:0] gd;
    apply_reset();
    gd            = {$urandom, $urandom};
    gnt_valid     = 1'b1;
    gnt_xid       = {2'd3, 4'd9};
    gnt_data      = gd;
    gnt_type      = 3'd5;
    out_gnt_ready = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({gnt_ready, out_gnt_valid, out_gnt_xid, out_gnt_data, out_gnt_type} !==
          {1'b0, 4'b1000, 4'd9, gd, 3'd5}) begin
        $display("FAIL gnt_hold[%0d]: got rdy=%b gv=%b xid=%h data=%h type=%0d want rdy=0 gv=1000 xid=9 data=%h type=5",
                 i, gnt_ready, out_gnt_valid, out_gnt_xid, out_gnt_data, out_gnt_type, gd);
      end else begin
        n_pass++;
      end
      @(negedge clk);
    end
    out_gnt_ready = 4'b1000;
    #1;
    n_checks++;
    if (gnt_ready !== 1'b1) begin
      $display("FAIL gnt_release: got %b want 1", gnt_ready);
    end else begin
      n_pass++;
    end
    @(negedge clk);
    gnt_valid = 1'b0;
    #1;
    n_checks++;
    if ({out_gnt_valid, route_err} !== {4'b0000, 1'b0}) begin
      $display("FAIL gnt_idle: got gv=%b err=%b want gv=0000 err=0",
               out_gnt_valid, route_err);
    end else begin
      n_pass++;
    end
    // Three-client instance: index 2 routes, index 3 is dropped.
    t_gnt_valid     = 1'b1;
    t_gnt_xid       = {2'd2, 4'd4};
    t_out_gnt_ready = 3'b000;
    #1;
    n_checks++;
    if ({t_out_gnt_valid, t_gnt_ready} !== {3'b100, 1'b0}) begin
      $display("FAIL n3_route2: got gv=%b rdy=%b want gv=100 rdy=0",
               t_out_gnt_valid, t_gnt_ready);
    end else begin
      n_pass++;
    end
    t_gnt_xid       = {2'd3, 4'd1};
    t_out_gnt_ready = 3'b111;
    #1;
    n_checks++;
    if ({t_out_gnt_valid, t_gnt_ready, t_route_err} !== {3'b000, 1'b1, 1'b0}) begin
      $display("FAIL n3_drop: got gv=%b rdy=%b err=%b want gv=000 rdy=1 err=0",
               t_out_gnt_valid, t_gnt_ready, t_route_err);
    end else begin
      n_pass++;
    end
    @(negedge clk);
    t_gnt_valid = 1'b0;
    #1;
    n_checks++;
    if (t_route_err !== 1'b1) begin
      $display("FAIL n3_err_set: got %b want 1", t_route_err);
    end else begin
      n_pass++;
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (t_route_err !== 1'b1) begin
      $display("FAIL n3_err_sticky: got %b want 1", t_route_err);
    end else begin
      n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_backpressure_reset();
    apply_reset();
    out_acq_ready = 1'b0;
    set_client(0, 1'b1, 32'hA000, 4'd1, 64'hAA, 3'd0);
    #1;
    n_checks++;
    if (in_acq_ready !== 4'b0001) begin
      $display("FAIL bp_first: got %b want 0001", in_acq_ready);
    end else begin
      n_pass++;
    end
    @(negedge clk);
    set_client(0, 1'b0, 32'h0, 4'd0, 64'h0, 3'd0);
    set_client(1, 1'b1, 32'hB000, 4'd2, 64'hBB, 3'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if ({out_acq_valid, out_acq_addr, out_acq_xid, out_acq_data, in_acq_ready} !==
          {1'b1, 32'hA000, 6'h01, 64'hAA, 4'b0000}) begin
        $display("FAIL bp_hold[%0d]: got v=%b addr=%h xid=%h data=%h ar=%b want v=1 addr=0000a000 xid=01 data=aa ar=0000",
                 i, out_acq_valid, out_acq_addr, out_acq_xid, out_acq_data, in_acq_ready);
      end else begin
        n_pass++;
      end
      @(negedge clk);
    end
    // Draining and refilling in the same cycle.
    out_acq_ready = 1'b1;
    #1;
    n_checks++;
    if (in_acq_ready !== 4'b0010) begin
      $display("FAIL bp_passthru: got %b want 0010", in_acq_ready);
    end else begin
      n_pass++;
    end
    @(negedge clk);
    set_client(1, 1'b0, 32'h0, 4'd0, 64'h0, 3'd0);
    set_client(2, 1'b1, 32'hC000, 4'd6, 64'hCC, 3'd3);
    #1;
    n_checks++;
    if (in_acq_ready !== 4'b0100) begin
      $display("FAIL rst_blk_beat1: got %b want 0100", in_acq_ready);
    end else begin
      n_pass++;
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if ({out_acq_valid, out_acq_xid[5:4]} !== {1'b1, 2'd2}) begin
      $display("FAIL rst_blk_beat2: got v=%b idx=%0d want v=1 idx=2",
               out_acq_valid, out_acq_xid[5:4]);
    end else begin
      n_pass++;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out_acq_valid, in_acq_ready} !== {1'b0, 4'b0000}) begin
      $display("FAIL rst_async: got v=%b ar=%b want v=0 ar=0000",
               out_acq_valid, in_acq_ready);
    end else begin
      n_pass++;
    end
    @(negedge clk);
    rst = 1'b0;
    set_client(2, 1'b1, 32'hC000, 4'd6, 64'hCC, 3'd0);
    set_client(0, 1'b1, 32'hD000, 4'd3, 64'hDD, 3'd0);
    #1;
    n_checks++;
    if (in_acq_ready !== 4'b0001) begin
      $display("FAIL rst_after_ptr: got %b want 0001", in_acq_ready);
    end else begin
      n_pass++;
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({out_acq_valid, out_acq_xid, out_acq_addr} !== {1'b1, 6'h03, 32'hD000}) begin
      $display("FAIL rst_after_out: got v=%b xid=%h addr=%h want v=1 xid=03 addr=0000d000",
               out_acq_valid, out_acq_xid, out_acq_addr);
    end else begin
      n_pass++;
    end
    idle_inputs();
  endtask

  // Random traffic compared against a transaction-level model. The model
  // tracks who may be served, the lock owner, beats remaining, outstanding
  // counts per client, and the one transaction waiting in the output stage.
  task automatic test_random();
    int          rr;
    int          owner;
    int          beats_seen;
    int          cnt [4];
    bit          hv;
    logic [31:0] ha;
    logic [5:0]  hx;
    logic [63:0] hd;
    logic [2:0]  ht;
    int          win;
    int          gi;
    bit          free;
    logic [3:0]  exp_ar;
    logic [3:0]  exp_gv;
    rr         = 0;
    owner      = -1;
    beats_seen = 0;
    hv         = 1'b0;
    ha         = '0;
    hx         = '0;
    hd         = '0;
    ht         = '0;
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < 4; c++) begin
        set_client(c, 1'($urandom_range(0, 99) < 60), $urandom,
                   4'($urandom_range(0, 15)), {$urandom, $urandom},
                   ($urandom_range(0, 3) == 0) ? 3'd3 : 3'($urandom_range(0, 7)));
      end
      out_acq_ready = 1'($urandom_range(0, 99) < 70);
      gnt_valid     = 1'($urandom_range(0, 1));
      gnt_xid       = 6'($urandom_range(0, 63));
      gnt_data      = {$urandom, $urandom};
      gnt_type      = 3'($urandom_range(0, 7));
      out_gnt_ready = 4'($urandom_range(0, 15));
      #1;
      free = !hv || out_acq_ready;
      win  = -1;
      if (free) begin
        for (int k = 0; k < 4; k++) begin
          int c;
          c = (rr + k) % 4;
          if (win < 0 && in_acq_valid[c] &&
              ((owner >= 0) ? (c == owner) : (cnt[c] < 2))) begin
            win = c;
          end
        end
      end
      exp_ar = (win >= 0) ? (4'b0001 << win) : 4'b0000;
      gi     = int'(gnt_xid[5:4]);
      exp_gv = gnt_valid ? (4'b0001 << gi) : 4'b0000;

      n_checks++;
      if (in_acq_ready !== exp_ar) begin
        $display("FAIL rand_in_ready[%0d]: got %b want %b", cyc, in_acq_ready, exp_ar);
      end else begin
        n_pass++;
      end
      n_checks++;
      if (out_acq_valid !== hv) begin
        $display("FAIL rand_out_valid[%0d]: got %b want %b", cyc, out_acq_valid, hv);
      end else begin
        n_pass++;
      end
      if (hv) begin
        n_checks++;
        if ({out_acq_addr, out_acq_xid, out_acq_data, out_acq_type} !== {ha, hx, hd, ht}) begin
          $display("FAIL rand_payload[%0d]: got %h/%h/%h/%h want %h/%h/%h/%h", cyc,
                   out_acq_addr, out_acq_xid, out_acq_data, out_acq_type, ha, hx, hd, ht);
        end else begin
          n_pass++;
        end
      end
      n_checks++;
      if ({out_gnt_valid, gnt_ready, out_gnt_xid} !==
          {exp_gv, out_gnt_ready[gi], gnt_xid[3:0]}) begin
        $display("FAIL rand_grant[%0d]: got gv=%b rdy=%b xid=%h want gv=%b rdy=%b xid=%h",
                 cyc, out_gnt_valid, gnt_ready, out_gnt_xid, exp_gv,
                 out_gnt_ready[gi], gnt_xid[3:0]);
      end else begin
        n_pass++;
      end

      // Advance the model across the coming rising edge.
      if (hv && out_acq_ready) hv = 1'b0;
      if (win >= 0) begin
        hv = 1'b1;
        ha = in_acq_addr[win*32 +: 32];
        hx = {2'(win), in_acq_xid[win*4 +: 4]};
        hd = in_acq_data[win*64 +: 64];
        ht = in_acq_type[win*3 +: 3];
        rr = (win + 1) % 4;
        if (owner < 0) begin
          if (ht == 3'd3) begin
            owner      = win;
            beats_seen = 1;
          end else begin
            cnt[win]++;
          end
        end else begin
          beats_seen++;
          if (beats_seen == 4) begin
            cnt[owner]++;
            owner      = -1;
            beats_seen = 0;
          end
        end
      end
      if (gnt_valid && out_gnt_ready[gi] && cnt[gi] > 0) cnt[gi]--;
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (route_err !== 1'b0) begin
      $display("FAIL rand_route_err: got %b want 0", route_err);
    end else begin
      n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_latency();
    test_round_robin();
    test_block_lock();
    test_outstanding_limit();
    test_grant_routing();
    test_backpressure_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tlink_acquire_arbiter.md
Name: tlink_acquire_arbiter

Overview:
- Parametrised N-client TileLink Acquire arbiter with a Grant return router, placed between N uncached clients and one manager port.
- Arbitrates Acquires round-robin and locks arbitration for multi-beat block writes.
- Tags each Acquire with the client index in the MSBs of client_xact_id, then decodes that tag on the Grant and routes the Grant back to the owning client.
- Limits outstanding transactions per client.

Parameters:
N_CLIENTS, 4, number of client ports (2..16); CIDX_W = $clog2(N_CLIENTS)
ADDR_W, 32, Acquire physical address width
XID_W, 4, client-side client_xact_id width
DATA_W, 64, beat data width
TYPE_W, 3, a_type/g_type width
BEATS, 4, beats in a multi-beat block write (power of 2, >=2)
WR_BLOCK_TYPE, 3'd3, a_type code that marks a multi-beat write
MAX_OUT, 2, maximum outstanding Acquires per client (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_acq_valid  in  N_CLIENTS  per-client Acquire valid
in_acq_ready  out  N_CLIENTS  per-client Acquire ready
in_acq_addr  in  N_CLIENTS*ADDR_W  packed Acquire addresses
in_acq_xid  in  N_CLIENTS*XID_W  packed client_xact_id
in_acq_data  in  N_CLIENTS*DATA_W  packed beat data
in_acq_type  in  N_CLIENTS*TYPE_W  packed a_type
out_acq_valid  out  1  manager Acquire valid
out_acq_ready  in  1  manager Acquire ready
out_acq_addr  out  ADDR_W  forwarded address
out_acq_xid  out  CIDX_W+XID_W  {client index, client xid}
out_acq_data  out  DATA_W  forwarded data
out_acq_type  out  TYPE_W  forwarded a_type
gnt_valid  in  1  manager Grant valid
gnt_ready  out  1  manager Grant ready
gnt_xid  in  CIDX_W+XID_W  tagged client_xact_id
gnt_data  in  DATA_W  Grant data
gnt_type  in  TYPE_W  g_type
out_gnt_valid  out  N_CLIENTS  per-client Grant valid
out_gnt_ready  in  N_CLIENTS  per-client Grant ready
out_gnt_xid  out  XID_W  stripped xid, broadcast to all clients
out_gnt_data  out  DATA_W  broadcast
out_gnt_type  out  TYPE_W  broadcast
route_err  out  1  sticky flag: Grant carried an index >= N_CLIENTS

Behaviour:
- Reset (async, rst=1):
  - out_acq_valid=0, in_acq_ready=0, route_err=0.
  - RR pointer=0, lock=0, beat counter=0, all outstanding counters=0.
  - out_gnt_valid and gnt_ready are combinational, with no reset value.
  - Asserting reset mid-burst discards the holding register and the lock.
- Output stage: a single holding register.
  - Free when out_acq_valid=0, or when out_acq_valid&&out_acq_ready in the same cycle.
  - An Acquire accepted at cycle t appears on out_acq_* at t+1.
  - Holding contents stay stable while valid&&!ready.
- Eligibility:
  - Client i is eligible when in_acq_valid[i]=1 and cnt[i] < MAX_OUT.
  - While lock=1, only the locked client is eligible, and the counter limit does not apply.
- Arbitration, state IDLE (lock=0):
  - When the output stage is free, grant the first eligible client at or after the RR pointer, wrapping modulo N_CLIENTS.
  - in_acq_ready is one-hot on the winner and 0 elsewhere.
  - On acceptance, RR pointer = winner+1 mod N_CLIENTS.
  - If the accepted a_type == WR_BLOCK_TYPE, go to LOCKED, set beat=1 and record the owner.
- LOCKED:
  - Only the owner may be accepted; beat increments on each accepted beat.
  - When the accepted beat is number BEATS (beat==BEATS-1 at acceptance), return to IDLE with beat=0.
  - A client that drops valid mid-burst stalls the arbiter; the lock is held indefinitely.
- Outstanding count:
  - cnt[i] increments when client i completes an Acquire: a single-beat accept, or the last beat of a block.
  - cnt[i] decrements when a Grant handshake completes to client i.
  - Increment and decrement in the same cycle leave cnt unchanged.
  - cnt saturates at 0 on decrement; a spurious Grant still routes.
- Grant routing (combinational, zero latency):
  - idx = gnt_xid[CIDX_W+XID_W-1:XID_W].
  - If idx < N_CLIENTS: out_gnt_valid[idx]=gnt_valid, other valids 0, gnt_ready=out_gnt_ready[idx].
  - If idx >= N_CLIENTS: all valids 0, gnt_ready=1 (dropped), route_err set on the handshake and held until reset.
  - out_gnt_xid = gnt_xid[XID_W-1:0].
- Acquires and Grants are independent; both may handshake in the same cycle.

Test Plan:
- Single-beat latency: client 2 sends xid=5, addr=0x1000, a_type=0, with out_acq_ready=1 -> at t+1, out_acq_xid={2'd2,4'd5} and addr=0x1000; in_acq_ready[2] is high for exactly one cycle.
- Round-robin order: all 4 clients valid continuously with single-beat Acquires, ready=1, MAX_OUT large enough -> acceptance order is 0,1,2,3,0,1.
- Block lock: client 1 issues WR_BLOCK with 4 beats while clients 0 and 3 are valid -> 4 consecutive client-1 beats with data unchanged, then client 3 is served next (pointer=2).
- Outstanding limit: MAX_OUT=2, client 0 issues 3 Acquires with no Grants -> the third is held off (in_acq_ready[0]=0); Grant xid={0,x} completes -> third Acquire accepted next cycle.
- Grant routing and backpressure: Grant xid={2'd3,4'd9} with out_gnt_ready[3]=0 for 3 cycles -> gnt_ready=0 for those 3 cycles; out_gnt_valid=4'b1000 and out_gnt_xid=9 are held stable. Separately, N_CLIENTS=3 with idx=3 -> Grant dropped, route_err=1.
- Output backpressure and reset: out_acq_ready=0 for 5 cycles -> held payload is stable and no further in_acq_ready. Assert rst during beat 2 of a block -> out_acq_valid=0 immediately; after release the RR pointer is 0 and a new single-beat Acquire from client 0 is accepted.
